// File: rtl/vga_fb_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_write_ctrl
// Description : Bus-mapped write controller in front of frame buffer port A
//               (160x120, 1 bpp, address {Y[6:0], X[7:0]}). Decodes an
//               8-register bus window, issues single-pixel writes, runs a
//               rectangle fill / clear-screen engine and arbitrates both onto
//               one buffer write per cycle. Also holds CONFIG_COLOURS.
//
// Ports       : CLK            system clock
//               RESET          synchronous active-high reset
//               BUS_ADDR[7:0]  bus address
//               BUS_DATA[7:0]  bus write data
//               BUS_WE         bus write strobe (one cycle per write)
//               FB_ADDR[14:0]  frame buffer address {Y,X}
//               FB_DATA        pixel value
//               FB_WE          frame buffer write enable
//               CONFIG_COLOURS {foreground, background} colours
//               BUSY           fill engine active
//               OVERRUN        sticky: queued pixel write was overwritten
//
// Options     : VGA_FB_AUTOINC_EN - when defined, each pixel write advances
//               X (wrapping into Y, Y wraps at the last row).
//
// Revision    : 1.0  initial release
// ============================================================================
module vga_fb_write_ctrl #(
  parameter logic [7:0]  BASE_ADDR    = 8'hB0,
  parameter int          SCREEN_W     = 160,
  parameter int          SCREEN_H     = 120,
  parameter logic [15:0] COLOUR_RESET = 16'h3333
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  BUS_ADDR,
  input  logic [7:0]  BUS_DATA,
  input  logic        BUS_WE,
  output logic [14:0] FB_ADDR,
  output logic        FB_DATA,
  output logic        FB_WE,
  output logic [15:0] CONFIG_COLOURS,
  output logic        BUSY,
  output logic        OVERRUN
);

  // Screen limits held at 9 bits so origin+size sums never wrap.
  localparam logic [8:0] c_SCREEN_W9 = 9'(SCREEN_W);
  localparam logic [8:0] c_SCREEN_H9 = 9'(SCREEN_H);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  // Shadow registers written by the bus
  logic [7:0]  r_x, r_w;
  logic [6:0]  r_y, r_h;
  logic [15:0] r_colours;

  // Latched fill parameters and cursor
  logic [7:0]  r_fx0;
  logic [8:0]  r_fxe, r_fye;
  logic [7:0]  r_cx;
  logic [6:0]  r_cy;
  logic        r_fval;

  // One-entry pending slot for bus pixel writes that collide with the fill
  logic        r_pend_v;
  logic [14:0] r_pend_addr;
  logic        r_pend_data;

  // Registered outputs
  logic [14:0] r_fb_addr;
  logic        r_fb_data, r_fb_we, r_busy, r_overrun;

  // Decode / datapath wires
  logic [7:0] w_offs;
  logic       w_hit;
  logic       w_wr_y, w_wr_x, w_wr_pix, w_wr_w, w_wr_h, w_wr_clo, w_wr_chi, w_wr_cmd;
  logic       w_pix_ok, w_cmd_go, w_clear, w_sempty;
  logic [7:0] w_sx0;
  logic [6:0] w_sy0;
  logic [8:0] w_sxe_raw, w_sye_raw, w_sxe, w_sye;
  logic [7:0] w_bx0, w_curx, w_nx;
  logic [6:0] w_cury, w_ny;
  logic [8:0] w_bxe, w_bye;
  logic       w_fill_act, w_slot_load, w_slot_issue, w_direct, w_fill_emit;
  logic       w_xlast, w_last, w_fill_val;

  always_comb begin
    // Window decode by offset so any BASE_ADDR alignment works
    w_offs   = BUS_ADDR - BASE_ADDR;
    w_hit    = BUS_WE && (w_offs < 8'd8);
    w_wr_y   = w_hit && (w_offs[2:0] == 3'd0);
    w_wr_x   = w_hit && (w_offs[2:0] == 3'd1);
    w_wr_pix = w_hit && (w_offs[2:0] == 3'd2);
    w_wr_w   = w_hit && (w_offs[2:0] == 3'd3);
    w_wr_h   = w_hit && (w_offs[2:0] == 3'd4);
    w_wr_clo = w_hit && (w_offs[2:0] == 3'd5);
    w_wr_chi = w_hit && (w_offs[2:0] == 3'd6);
    w_wr_cmd = w_hit && (w_offs[2:0] == 3'd7);

    // Off-screen pixel writes are dropped before they reach the slot
    w_pix_ok = w_wr_pix && ({1'b0, r_x} < c_SCREEN_W9) && ({2'b00, r_y} < c_SCREEN_H9);

    // Start accepted only when fully idle (BUSY lingers one cycle after DONE)
    w_cmd_go = w_wr_cmd && (BUS_DATA[2] || BUS_DATA[0]) && (r_state == S_IDLE) && !r_busy;
    w_clear  = BUS_DATA[2];

    // Fill bounds as they would be latched by a start this cycle
    w_sx0     = w_clear ? 8'd0 : r_x;
    w_sy0     = w_clear ? 7'd0 : r_y;
    w_sxe_raw = {1'b0, w_sx0} + (w_clear ? c_SCREEN_W9 : {1'b0, r_w});
    w_sye_raw = {2'b00, w_sy0} + (w_clear ? c_SCREEN_H9 : {2'b00, r_h});
    w_sxe     = (w_sxe_raw > c_SCREEN_W9) ? c_SCREEN_W9 : w_sxe_raw;
    w_sye     = (w_sye_raw > c_SCREEN_H9) ? c_SCREEN_H9 : w_sye_raw;
    w_sempty  = (!w_clear && ((r_w == 8'd0) || (r_h == 7'd0)))
             || ({1'b0, w_sx0} >= c_SCREEN_W9) || ({2'b00, w_sy0} >= c_SCREEN_H9);

    // On the start cycle the engine works from the fresh values so the
    // first pixel can go out on the very next cycle.
    if (r_state == S_IDLE) begin
      w_bx0      = w_sx0;
      w_bxe      = w_sxe;
      w_bye      = w_sye;
      w_curx     = w_sx0;
      w_cury     = w_sy0;
      w_fill_val = BUS_DATA[1];
    end else begin
      w_bx0      = r_fx0;
      w_bxe      = r_fxe;
      w_bye      = r_fye;
      w_curx     = r_cx;
      w_cury     = r_cy;
      w_fill_val = r_fval;
    end

    w_fill_act = (r_state == S_FILL) || (w_cmd_go && !w_sempty);

    // Arbitration: a new bus pixel goes to the slot whenever the fill owns
    // the port or the slot is occupied (replacing it); a waiting slot entry
    // takes the port ahead of the fill; otherwise bus pixels go straight out.
    w_slot_load  = w_pix_ok && ((r_state == S_FILL) || r_pend_v);
    w_slot_issue = r_pend_v && !w_slot_load;
    w_direct     = w_pix_ok && !w_slot_load;
    w_fill_emit  = w_fill_act && !w_slot_issue && !w_direct;

    w_xlast = (({1'b0, w_curx} + 9'd1) == w_bxe);
    w_last  = w_xlast && (({2'b00, w_cury} + 9'd1) == w_bye);

    w_nx = w_curx;
    w_ny = w_cury;
    if (w_fill_emit) begin
      if (w_xlast) begin
        w_nx = w_bx0;
        w_ny = w_cury + 7'd1;
      end else begin
        w_nx = w_curx + 8'd1;
      end
    end

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_go) begin
          if (w_sempty || (w_fill_emit && w_last)) w_state_nxt = S_DONE;
          else                                     w_state_nxt = S_FILL;
        end
      end
      S_FILL:  if (w_fill_emit && w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_x         <= 8'd0;
      r_y         <= 7'd0;
      r_w         <= 8'd0;
      r_h         <= 7'd0;
      r_colours   <= COLOUR_RESET;
      r_fx0       <= 8'd0;
      r_fxe       <= 9'd0;
      r_fye       <= 9'd0;
      r_cx        <= 8'd0;
      r_cy        <= 7'd0;
      r_fval      <= 1'b0;
      r_pend_v    <= 1'b0;
      r_pend_addr <= 15'd0;
      r_pend_data <= 1'b0;
      r_fb_addr   <= 15'd0;
      r_fb_data   <= 1'b0;
      r_fb_we     <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_wr_y)   r_y            <= BUS_DATA[6:0];
      if (w_wr_x)   r_x            <= BUS_DATA;
      if (w_wr_w)   r_w            <= BUS_DATA;
      if (w_wr_h)   r_h            <= BUS_DATA[6:0];
      if (w_wr_clo) r_colours[7:0]  <= BUS_DATA;
      if (w_wr_chi) r_colours[15:8] <= BUS_DATA;

`ifdef VGA_FB_AUTOINC_EN
      // Advance the write position after every pixel write, raster order
      if (w_wr_pix) begin
        if ({1'b0, r_x} >= (c_SCREEN_W9 - 9'd1)) begin
          r_x <= 8'd0;
          if ({2'b00, r_y} >= (c_SCREEN_H9 - 9'd1)) r_y <= 7'd0;
          else                                      r_y <= r_y + 7'd1;
        end else begin
          r_x <= r_x + 8'd1;
        end
      end
`else
      // X/Y move only on explicit register writes
`endif

      if (w_cmd_go) begin
        r_fx0  <= w_sx0;
        r_fxe  <= w_sxe;
        r_fye  <= w_sye;
        r_fval <= BUS_DATA[1];
      end
      r_cx <= w_nx;
      r_cy <= w_ny;

      if (w_slot_load) begin
        r_pend_v    <= 1'b1;
        r_pend_addr <= {r_y, r_x};
        r_pend_data <= BUS_DATA[0];
        if (r_pend_v) r_overrun <= 1'b1;
      end else if (w_slot_issue) begin
        r_pend_v <= 1'b0;
      end

      r_fb_we <= 1'b0;
      if (w_slot_issue) begin
        r_fb_we   <= 1'b1;
        r_fb_addr <= r_pend_addr;
        r_fb_data <= r_pend_data;
      end else if (w_direct) begin
        r_fb_we   <= 1'b1;
        r_fb_addr <= {r_y, r_x};
        r_fb_data <= BUS_DATA[0];
      end else if (w_fill_emit) begin
        r_fb_we   <= 1'b1;
        r_fb_addr <= {w_cury, w_curx};
        r_fb_data <= w_fill_val;
      end

      // Covers FILL and DONE, plus the cycle the DONE state hands back
      r_busy <= (r_state != S_IDLE) || (w_state_nxt != S_IDLE);
    end
  end

  assign FB_ADDR        = r_fb_addr;
  assign FB_DATA        = r_fb_data;
  assign FB_WE          = r_fb_we;
  assign CONFIG_COLOURS = r_colours;
  assign BUSY           = r_busy;
  assign OVERRUN        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fb_write_ctrl
// Description : Directed self-checking bench for vga_fb_write_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vga_fb_write_ctrl;

  localparam logic [7:0] c_B = 8'hB0;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  BUS_ADDR, BUS_DATA;
  logic        BUS_WE;
  logic [14:0] FB_ADDR;
  logic        FB_DATA, FB_WE, BUSY, OVERRUN;
  logic [15:0] CONFIG_COLOURS;

  vga_fb_write_ctrl dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .BUS_ADDR       (BUS_ADDR),
    .BUS_DATA       (BUS_DATA),
    .BUS_WE         (BUS_WE),
    .FB_ADDR        (FB_ADDR),
    .FB_DATA        (FB_DATA),
    .FB_WE          (FB_WE),
    .CONFIG_COLOURS (CONFIG_COLOURS),
    .BUSY           (BUSY),
    .OVERRUN        (OVERRUN)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor, sampled 1 time unit after each rising edge
  logic        mon_en = 1'b0;
  logic [15:0] wq[$];
  logic [15:0] eq[$];
  int          busy_cyc;

  always @(posedge CLK) begin
    #1;
    if (mon_en) begin
      if (FB_WE === 1'b1) wq.push_back({FB_DATA, FB_ADDR});
      if (BUSY === 1'b1)  busy_cyc++;
    end
  end

  function automatic logic [15:0] pk(input int x, input int y, input int d);
    logic [15:0] v;
    v = {1'(d), 7'(y), 8'(x)};
    return v;
  endfunction

  task automatic bw(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    BUS_ADDR = a;
    BUS_DATA = d;
    BUS_WE   = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      BUS_WE = 1'b0;
    end
  endtask

  task automatic wait_busy_low(input int max);
    int k;
    k = 0;
    while (BUSY === 1'b1 && k < max) begin
      @(negedge CLK);
      BUS_WE = 1'b0;
      k++;
    end
    if (k >= max) chk("busy_timeout", 32'(k), 32'(max - 1));
  endtask

  task automatic mon_start();
    wq.delete();
    busy_cyc = 0;
    mon_en   = 1'b1;
  endtask

  task automatic chk_list(input string tag);
    chk({tag, "_count"}, 32'(wq.size()), 32'(eq.size()));
    for (int i = 0; i < eq.size() && i < wq.size(); i++)
      chk(tag, {16'd0, wq[i]}, {16'd0, eq[i]});
  endtask

  logic seen [0:32767];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, dup, ones;
    logic [14:0] a;

    RESET = 1'b1; BUS_WE = 1'b0; BUS_ADDR = 8'h00; BUS_DATA = 8'h00;
    repeat (3) @(negedge CLK);

    // Reset state
    chk("rst_fb_we",   32'(FB_WE), 0);
    chk("rst_fb_addr", 32'(FB_ADDR), 0);
    chk("rst_fb_data", 32'(FB_DATA), 0);
    chk("rst_busy",    32'(BUSY), 0);
    chk("rst_overrun", 32'(OVERRUN), 0);
    chk("rst_colours", 32'(CONFIG_COLOURS), 32'h3333);
    RESET = 1'b0;

    // Single pixel write
    bw(c_B + 8'd0, 8'd5);
    bw(c_B + 8'd1, 8'd10);
    bw(c_B + 8'd2, 8'd1);
    idle(1);
    chk("pix_we",   32'(FB_WE), 1);
    chk("pix_addr", 32'(FB_ADDR), 32'h050A);
    chk("pix_data", 32'(FB_DATA), 1);
    idle(1);
    chk("pix_we_drop", 32'(FB_WE), 0);

    // Colour registers
    bw(c_B + 8'd5, 8'hA5);
    idle(1);
    chk("colour_lo", 32'(CONFIG_COLOURS), 32'h33A5);
    bw(c_B + 8'd6, 8'h5A);
    idle(1);
    chk("colour_hi", 32'(CONFIG_COLOURS), 32'h5AA5);

    // Off-screen X suppresses the write
    mon_start();
    bw(c_B + 8'd1, 8'd200);
    bw(c_B + 8'd2, 8'd1);
    idle(4);
    mon_en = 1'b0;
    chk("offscreen_writes", 32'(wq.size()), 0);

    // Addresses outside the window are ignored
    bw(c_B + 8'd1, 8'd20);
    bw(8'hB8, 8'd77);
    bw(8'hBA, 8'd1);
    idle(1);
    chk("outwin_we", 32'(FB_WE), 0);
    bw(c_B + 8'd2, 8'd0);
    idle(1);
    chk("outwin_addr", 32'(FB_ADDR), 32'h0514);
    chk("outwin_data", 32'(FB_DATA), 0);

    // Clipped rectangle at the right edge
    bw(c_B + 8'd1, 8'd158);
    bw(c_B + 8'd0, 8'd0);
    bw(c_B + 8'd3, 8'd4);
    bw(c_B + 8'd4, 8'd2);
    mon_start();
    bw(c_B + 8'd7, 8'h03);
    idle(1);
    chk("rect_first_we", 32'(FB_WE), 1);
    chk("rect_busy",     32'(BUSY), 1);
    wait_busy_low(100);
    idle(2);
    mon_en = 1'b0;
    eq.delete();
    eq.push_back(pk(158, 0, 1)); eq.push_back(pk(159, 0, 1));
    eq.push_back(pk(158, 1, 1)); eq.push_back(pk(159, 1, 1));
    chk_list("rect");
    chk("rect_busy_cycles", 32'(busy_cyc), 5);

    // Zero width: no writes, BUSY through DONE only
    bw(c_B + 8'd1, 8'd5);
    bw(c_B + 8'd0, 8'd5);
    bw(c_B + 8'd3, 8'd0);
    bw(c_B + 8'd4, 8'd3);
    mon_start();
    bw(c_B + 8'd7, 8'h01);
    idle(1);
    wait_busy_low(100);
    idle(2);
    mon_en = 1'b0;
    chk("zero_w_writes", 32'(wq.size()), 0);
    chk("zero_w_busy",   32'(busy_cyc), 2);

    // Clear screen; a second start during BUSY must be ignored
    mon_start();
    bw(c_B + 8'd7, 8'h04);
    idle(5);
    bw(c_B + 8'd3, 8'd3);
    bw(c_B + 8'd4, 8'd1);
    bw(c_B + 8'd7, 8'h06);
    idle(1);
    wait_busy_low(25000);
    idle(2);
    mon_en = 1'b0;
    for (int i = 0; i < 32768; i++) seen[i] = 1'b0;
    bad = 0; dup = 0; ones = 0;
    for (int i = 0; i < wq.size(); i++) begin
      a = wq[i][14:0];
      if (a[7:0] >= 8'd160 || a[14:8] >= 7'd120) bad++;
      else if (seen[a]) dup++;
      seen[a] = 1'b1;
      if (wq[i][15]) ones++;
    end
    chk("clear_count",  32'(wq.size()), 19200);
    chk("clear_offscr", 32'(bad), 0);
    chk("clear_dup",    32'(dup), 0);
    chk("clear_value",  32'(ones), 0);
    chk("clear_busy",   32'(busy_cyc), 19201);

    // Bus pixel interleaved into a fill
    bw(c_B + 8'd1, 8'd0);
    bw(c_B + 8'd0, 8'd20);
    bw(c_B + 8'd3, 8'd10);
    bw(c_B + 8'd4, 8'd1);
    mon_start();
    bw(c_B + 8'd7, 8'h03);
    bw(c_B + 8'd0, 8'd50);
    bw(c_B + 8'd1, 8'd7);
    bw(c_B + 8'd2, 8'd1);
    idle(1);
    wait_busy_low(100);
    idle(2);
    mon_en = 1'b0;
    eq.delete();
    for (int x = 0; x < 4; x++) eq.push_back(pk(x, 20, 1));
    eq.push_back(pk(7, 50, 1));
    for (int x = 4; x < 10; x++) eq.push_back(pk(x, 20, 1));
    chk_list("ilv");
    chk("ilv_busy",    32'(busy_cyc), 12);
    chk("ilv_overrun", 32'(OVERRUN), 0);

    // Back-to-back bus pixels during a fill: overrun, second one wins
    bw(c_B + 8'd1, 8'd0);
    bw(c_B + 8'd0, 8'd30);
    bw(c_B + 8'd3, 8'd12);
    bw(c_B + 8'd4, 8'd1);
    mon_start();
    bw(c_B + 8'd7, 8'h01);
    bw(c_B + 8'd0, 8'd60);
    bw(c_B + 8'd1, 8'd3);
    bw(c_B + 8'd2, 8'd0);
    bw(c_B + 8'd2, 8'd1);
    idle(1);
    wait_busy_low(100);
    idle(2);
    mon_en = 1'b0;
    eq.delete();
    for (int x = 0; x < 5; x++) eq.push_back(pk(x, 30, 0));
    eq.push_back(pk(3, 60, 1));
    for (int x = 5; x < 12; x++) eq.push_back(pk(x, 30, 0));
    chk_list("ovr");
    chk("ovr_busy", 32'(busy_cyc), 14);
    chk("ovr_flag", 32'(OVERRUN), 1);
    idle(3);
    chk("ovr_sticky", 32'(OVERRUN), 1);

    // Reset in the middle of a clear
    bw(c_B + 8'd7, 8'h04);
    idle(20);
    RESET = 1'b1;
    @(negedge CLK);
    chk("midrst_we",      32'(FB_WE), 0);
    chk("midrst_busy",    32'(BUSY), 0);
    chk("midrst_overrun", 32'(OVERRUN), 0);
    chk("midrst_colours", 32'(CONFIG_COLOURS), 32'h3333);
    chk("midrst_addr",    32'(FB_ADDR), 0);
    RESET = 1'b0;
    mon_start();
    idle(30);
    mon_en = 1'b0;
    chk("midrst_no_writes", 32'(wq.size()), 0);
    bw(c_B + 8'd2, 8'd1);
    idle(1);
    chk("midrst_pix_we",   32'(FB_WE), 1);
    chk("midrst_pix_addr", 32'(FB_ADDR), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
